alu_op_sequencer: RTL and testbench

//  Initiator side of the al_unit operand/opcode interface. Accepts one ALU operation per

---
 rtl/alu_op_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Initiator side of the al_unit operand/opcode interface. It accepts one ALU
//   operation per request handshake and drives the operands and opcode into
//   al_unit from registers. After a settle interval it captures the result and
//   the zero flag, then returns them on a response handshake. It also keeps
//   saturating counts of completed operations and of zero results.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_ra, req_rb, req_aluc    operation to run
//   alu_ra, alu_rb, cu_aluc     registered drive into al_unit
//   alu_result, alu_zero        al_unit outputs (combinational)
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_zero        captured al_unit outputs
//   busy                        state != IDLE
//   op_count, zero_count        saturating completion / zero-result counters
module alu_op_sequencer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_ra,
  input  logic [WIDTH-1:0] req_rb,
  input  logic [3:0]       req_aluc,
  output logic [WIDTH-1:0] alu_ra,
  output logic [WIDTH-1:0] alu_rb,
  output logic [3:0]       cu_aluc,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] zero_count
);

  // A settle interval of zero still needs one edge for al_unit to respond.
  localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 : SETTLE;
  localparam int unsigned SC_W       = (SETTLE_EFF < 2) ? 1 : $clog2(SETTLE_EFF + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SC_W-1:0]    settle_q, settle_d;
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic [WIDTH-1:0]   rb_q, rb_d;
  logic [3:0]         aluc_q, aluc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic [CNT_W-1:0]   op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0]   zero_cnt_q, zero_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      settle_q   <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      aluc_q     <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      op_cnt_q   <= '0;
      zero_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      aluc_q     <= aluc_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      op_cnt_q   <= op_cnt_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    aluc_d     = aluc_q;
    result_d   = result_q;
    zero_d     = zero_q;
    op_cnt_d   = op_cnt_q;
    zero_cnt_d = zero_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ra_d     = req_ra;
          rb_d     = req_rb;
          aluc_d   = req_aluc;
          settle_d = SC_W'(SETTLE_EFF);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (settle_q == SC_W'(1)) begin
          result_d = alu_result;
          zero_d   = alu_zero;
          state_d  = S_RESP;
        end else begin
          settle_d = settle_q - SC_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (op_cnt_q != '1) begin
            op_cnt_d = op_cnt_q + CNT_W'(1);
          end
          if (zero_q && (zero_cnt_q != '1)) begin
            zero_cnt_d = zero_cnt_q + CNT_W'(1);
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake flags come from the state register alone, so no input reaches them combinationally.
  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign alu_ra     = ra_q;
  assign alu_rb     = rb_q;
  assign cu_aluc    = aluc_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign op_count   = op_cnt_q;
  assign zero_count = zero_cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: instance A uses the default parameters, and
// instance B uses SETTLE=3 with CNT_W=2. A small behavioural al_unit stands in
// for the ALU. Opcode 4'b0001 subtracts and every other opcode adds.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // ---------------- instance A: SETTLE=1, CNT_W=16 ----------------
  logic        rst_na, req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a;
  logic [31:0] req_ra_a, req_rb_a, alu_ra_a, alu_rb_a, alu_result_a, rsp_result_a;
  logic [3:0]  req_aluc_a, cu_aluc_a;
  logic        alu_zero_a, rsp_zero_a, busy_a;
  logic [15:0] op_count_a, zero_count_a;

  assign alu_result_a = (cu_aluc_a == 4'b0001) ? alu_ra_a - alu_rb_a : alu_ra_a + alu_rb_a;
  assign alu_zero_a   = (alu_result_a == 32'd0);

  alu_op_sequencer #(.WIDTH(32), .SETTLE(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_na),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_ra(req_ra_a), .req_rb(req_rb_a), .req_aluc(req_aluc_a),
    .alu_ra(alu_ra_a), .alu_rb(alu_rb_a), .cu_aluc(cu_aluc_a),
    .alu_result(alu_result_a), .alu_zero(alu_zero_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_result(rsp_result_a), .rsp_zero(rsp_zero_a),
    .busy(busy_a), .op_count(op_count_a), .zero_count(zero_count_a)
  );

  // ---------------- instance B: SETTLE=3, CNT_W=2 ----------------
  logic        rst_nb, req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b;
  logic [31:0] req_ra_b, req_rb_b, alu_ra_b, alu_rb_b, alu_result_b, rsp_result_b;
  logic [3:0]  req_aluc_b, cu_aluc_b;
  logic        alu_zero_b, rsp_zero_b, busy_b;
  logic [1:0]  op_count_b, zero_count_b;

  assign alu_result_b = (cu_aluc_b == 4'b0001) ? alu_ra_b - alu_rb_b : alu_ra_b + alu_rb_b;
  assign alu_zero_b   = (alu_result_b == 32'd0);

  alu_op_sequencer #(.WIDTH(32), .SETTLE(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_nb),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_ra(req_ra_b), .req_rb(req_rb_b), .req_aluc(req_aluc_b),
    .alu_ra(alu_ra_b), .alu_rb(alu_rb_b), .cu_aluc(cu_aluc_b),
    .alu_result(alu_result_b), .alu_zero(alu_zero_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_result(rsp_result_b), .rsp_zero(rsp_zero_b),
    .busy(busy_b), .op_count(op_count_b), .zero_count(zero_count_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_na = 1'b0; req_valid_a = 1'b0; rsp_ready_a = 1'b0;
    req_ra_a = '0; req_rb_a = '0; req_aluc_a = '0;
    rst_nb = 1'b0; req_valid_b = 1'b0; rsp_ready_b = 1'b0;
    req_ra_b = '0; req_rb_b = '0; req_aluc_b = '0;

    // 1: reset values
    tick(); tick();
    check("rst_alu_ra",   alu_ra_a, 32'd0);
    check("rst_alu_rb",   alu_rb_a, 32'd0);
    check("rst_cu_aluc",  32'(cu_aluc_a), 32'd0);
    check("rst_rsp_valid",32'(rsp_valid_a), 32'd0);
    check("rst_rsp_res",  rsp_result_a, 32'd0);
    check("rst_rsp_zero", 32'(rsp_zero_a), 32'd0);
    check("rst_busy",     32'(busy_a), 32'd0);
    check("rst_op_cnt",   32'(op_count_a), 32'd0);
    check("rst_zero_cnt", 32'(zero_count_a), 32'd0);
    rst_na = 1'b1; rst_nb = 1'b1;
    tick();
    check("rel_req_ready", 32'(req_ready_a), 32'd1);

    // 2: 0 - 1
    req_valid_a = 1'b1; req_ra_a = 32'd0; req_rb_a = 32'd1; req_aluc_a = 4'b0001;
    tick();
    req_valid_a = 1'b0;
    check("t2_cu_aluc",   32'(cu_aluc_a), 32'd1);
    check("t2_busy",      32'(busy_a), 32'd1);
    check("t2_req_ready", 32'(req_ready_a), 32'd0);
    check("t2_rsp_early", 32'(rsp_valid_a), 32'd0);
    tick();
    check("t2_rsp_valid", 32'(rsp_valid_a), 32'd1);
    check("t2_rsp_res",   rsp_result_a, 32'hFFFF_FFFF);
    check("t2_rsp_zero",  32'(rsp_zero_a), 32'd0);
    rsp_ready_a = 1'b1;
    tick();
    rsp_ready_a = 1'b0;
    check("t2_rsp_done",  32'(rsp_valid_a), 32'd0);
    check("t2_op_cnt",    32'(op_count_a), 32'd1);
    check("t2_zero_cnt",  32'(zero_count_a), 32'd0);
    check("t2_res_kept",  rsp_result_a, 32'hFFFF_FFFF);

    // 3: 5 - 5 -> zero
    req_valid_a = 1'b1; req_ra_a = 32'd5; req_rb_a = 32'd5; req_aluc_a = 4'b0001;
    tick();
    req_valid_a = 1'b0;
    tick();
    check("t3_rsp_valid", 32'(rsp_valid_a), 32'd1);
    check("t3_rsp_res",   rsp_result_a, 32'd0);
    check("t3_rsp_zero",  32'(rsp_zero_a), 32'd1);
    rsp_ready_a = 1'b1;
    tick();
    rsp_ready_a = 1'b0;
    check("t3_op_cnt",    32'(op_count_a), 32'd2);
    check("t3_zero_cnt",  32'(zero_count_a), 32'd1);

    // 4: backpressure while a new request is held asserted
    req_valid_a = 1'b1; req_ra_a = 32'd7; req_rb_a = 32'd2; req_aluc_a = 4'b0001;
    tick();
    req_ra_a = 32'd100; req_rb_a = 32'd1; req_aluc_a = 4'b0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_valid", 32'(rsp_valid_a), 32'd1);
      check("t4_hold_res",   rsp_result_a, 32'd5);
      check("t4_req_ready",  32'(req_ready_a), 32'd0);
      check("t4_no_capture", alu_ra_a, 32'd7);
      tick();
    end
    check("t4_hold_end",  rsp_result_a, 32'd5);
    rsp_ready_a = 1'b1;
    tick();
    rsp_ready_a = 1'b0;
    check("t4_op_cnt",    32'(op_count_a), 32'd3);
    check("t4_idle_ra",   alu_ra_a, 32'd7);
    check("t4_idle_rdy",  32'(req_ready_a), 32'd1);
    tick();
    req_valid_a = 1'b0;
    check("t4_new_ra",    alu_ra_a, 32'd100);
    check("t4_new_aluc",  32'(cu_aluc_a), 32'd0);
    tick();
    check("t4_new_res",   rsp_result_a, 32'd101);
    rsp_ready_a = 1'b1;
    tick();
    rsp_ready_a = 1'b0;
    check("t4_op_cnt2",   32'(op_count_a), 32'd4);
    check("t4_zero_cnt",  32'(zero_count_a), 32'd1);

    // 5: SETTLE=3, reset while waiting
    req_valid_b = 1'b1; req_ra_b = 32'd9; req_rb_b = 32'd4; req_aluc_b = 4'b0001;
    tick();
    req_valid_b = 1'b0;
    tick();
    check("t5_busy_wait", 32'(busy_b), 32'd1);
    check("t5_not_resp",  32'(rsp_valid_b), 32'd0);
    #2 rst_nb = 1'b0;
    #1;
    check("t5_abort_busy", 32'(busy_b), 32'd0);
    check("t5_abort_rdy",  32'(req_ready_b), 32'd1);
    check("t5_abort_ra",   alu_ra_b, 32'd0);
    check("t5_abort_cnt",  32'(op_count_b), 32'd0);
    tick();
    rst_nb = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        seen |= rsp_valid_b;
      end
      check("t5_no_rsp", 32'(seen), 32'd0);
    end
    check("t5_res_clear", rsp_result_a == 32'd0 ? 32'd0 : 32'(rsp_result_b), 32'(rsp_result_b));
    check("t5_rsp_res0",  rsp_result_b, 32'd0);

    // 6: SETTLE=3 latency and CNT_W=2 saturation
    for (int k = 0; k < 5; k++) begin
      req_valid_b = 1'b1; req_ra_b = 32'(k + 3); req_rb_b = 32'(k + 3); req_aluc_b = 4'b0001;
      tick();
      req_valid_b = 1'b0;
      tick(); tick();
      check("t6_not_yet", 32'(rsp_valid_b), 32'd0);
      tick();
      check("t6_rsp_valid", 32'(rsp_valid_b), 32'd1);
      check("t6_rsp_zero",  32'(rsp_zero_b), 32'd1);
      rsp_ready_b = 1'b1;
      tick();
      rsp_ready_b = 1'b0;
      check("t6_op_cnt",   32'(op_count_b),   (k < 3) ? 32'(k + 1) : 32'd3);
      check("t6_zero_cnt", 32'(zero_count_b), (k < 3) ? 32'(k + 1) : 32'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
